// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared types and helpers for the iterative bit-scan encoder.
//   state_e     : scan controller states (IDLE, SCAN)
//   MIN_WIDTH / MAX_WIDTH : legal range of the request-vector width
//   idx_width() : index width derived from the request-vector width
//   keep_bit()  : per-bit term of the single-bit clear mask
// -----------------------------------------------------------------------------
package encoder_pkg;

    localparam int unsigned MIN_WIDTH = 32'd2;
    localparam int unsigned MAX_WIDTH = 32'd256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Index width for a given vector width (never narrower than one bit).
    function automatic int unsigned idx_width(input int unsigned w);
        if (w <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(w);
        end
    endfunction

    // One bit of a mask that clears exactly bit clr_idx: 0 at that position, 1 elsewhere.
    function automatic logic keep_bit(input int unsigned pos, input int unsigned clr_idx);
        if (pos == clr_idx) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/encoder_ffs.sv
// -----------------------------------------------------------------------------
// encoder_ffs
// Combinational find-first-set over a WIDTH-bit vector.
//   vec            : input vector
//   idx            : position of the lowest set bit (highest if MSB_FIRST=1),
//                    0 when no bit is set
//   any            : at least one bit set
//   onehot_or_zero : at most one bit set
// -----------------------------------------------------------------------------
module encoder_ffs
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot_or_zero
);

    // Priority scan: walk from the far end so that the preferred bit is written last.
    always_comb begin
        int pos;
        idx = {IDX_W{1'b0}};
        pos = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (MSB_FIRST) begin
                pos = k;
            end else begin
                pos = WIDTH - 1 - k;
            end
            if (vec[pos]) begin
                idx = IDX_W'(pos);
            end else begin
                idx = idx;
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    always_comb begin
        any            = |vec;
        onehot_or_zero = ((vec & (vec - WIDTH'(1))) == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/encoder_bitscan_iter.sv
// -----------------------------------------------------------------------------
// encoder_bitscan_iter
// Accepts a WIDTH-bit request vector over valid/ready and emits the index of
// every set bit, one per output beat, in ascending (MSB_FIRST=0) or descending
// (MSB_FIRST=1) order. The final beat of a vector carries out_last. An all-zero
// vector yields a single beat with out_idx=0, out_zero=1, out_last=1.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   enable          : gates acceptance of new vectors only
//   in_valid/in_ready/in_vec          : request-vector handshake
//   out_valid/out_ready               : output-beat handshake
//   out_idx/out_last/out_zero         : beat payload
//   onehot_err      : sticky "accepted vector was not one-hot" flag, present
//                     only when ENCODER_ONEHOT_CHK_EN is defined
//
// Beat payload is registered: on every edge the next mask is pushed through
// the find-first-set logic and the result is captured, so out_* reflect the
// registered mask with no path from in_* to out_* inside a cycle.
// -----------------------------------------------------------------------------
module encoder_bitscan_iter
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = idx_width(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
`ifdef ENCODER_ONEHOT_CHK_EN
    ,
    output logic             onehot_err
`endif
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WIDTH-1:0]   mask_r;
    logic [WIDTH-1:0]   mask_nxt_s;
    logic [WIDTH-1:0]   clr_mask_s;
    logic               zero_flag_r;
    logic               zero_nxt_s;
    logic               accept_s;
    logic               out_valid_r;
    logic [IDX_W-1:0]   out_idx_r;
    logic               out_last_r;
    logic               out_zero_r;
    logic [IDX_W-1:0]   nxt_idx_s;
    logic               nxt_any_s;
    logic               nxt_single_s;

    // New vectors are only taken while idle, enabled and out of reset.
    assign in_ready = (state_r == IDLE) && enable && !reset;

    // Mask that removes the bit currently presented on out_idx.
    always_comb begin
        clr_mask_s = {WIDTH{1'b1}};
        for (int b = 0; b < WIDTH; b++) begin
            clr_mask_s[b] = keep_bit($unsigned(b), 32'(out_idx_r));
        end
    end

    // Next-state and next-mask logic for the scan controller.
    always_comb begin
        state_nxt_s = state_r;
        mask_nxt_s  = mask_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_s    = 1'b1;
                    mask_nxt_s  = in_vec;
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (out_valid_r && out_ready) begin
                    mask_nxt_s = mask_r & clr_mask_s;
                    if (out_last_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                mask_nxt_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // On accept the next mask is the vector itself, so the scanner's "any" tells us if it was zero.
    always_comb begin
        if (accept_s) begin
            zero_nxt_s = !nxt_any_s;
        end else begin
            zero_nxt_s = zero_flag_r;
        end
    end

    encoder_ffs #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_ffs (
        .vec            (mask_nxt_s),
        .idx            (nxt_idx_s),
        .any            (nxt_any_s),
        .onehot_or_zero (nxt_single_s)
    );

    // State, mask and registered beat payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mask_r      <= {WIDTH{1'b0}};
            zero_flag_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= {IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            out_zero_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mask_r      <= mask_nxt_s;
            zero_flag_r <= zero_nxt_s;
            out_valid_r <= (state_nxt_s == SCAN);
            out_idx_r   <= nxt_idx_s;
            out_last_r  <= nxt_single_s;
            out_zero_r  <= zero_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign out_zero  = out_zero_r;

`ifdef ENCODER_ONEHOT_CHK_EN
    logic onehot_err_r;

    // Sticky flag: any accepted vector that is zero or has two or more bits set.
    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_err_r <= 1'b0;
        end else if (accept_s && !(nxt_any_s && nxt_single_s)) begin
            onehot_err_r <= 1'b1;
        end else begin
            onehot_err_r <= onehot_err_r;
        end
    end

    assign onehot_err = onehot_err_r;
`endif

endmodule

// File: tb/tb_encoder_bitscan_iter.sv
// -----------------------------------------------------------------------------
// Bench for encoder_bitscan_iter: one ascending and one descending instance
// share the same stimulus. A queue model expands each accepted vector into
// its expected beats and is compared against both instances every cycle;
// directed scenarios additionally check logged beats against literal lists.
// -----------------------------------------------------------------------------
module tb_encoder_bitscan_iter;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_vec    = 16'h0000;

    logic       l_ready, l_valid, l_last, l_zero;
    logic [3:0] l_idx;
    logic       m_ready, m_valid, m_last, m_zero;
    logic [3:0] m_idx;
`ifdef ENCODER_ONEHOT_CHK_EN
    logic       l_err, m_err;
`endif

    int tests = 0;
    int fails = 0;

    beat_t q_l[$];
    beat_t q_m[$];
    beat_t log_l[$];
    beat_t log_m[$];
    beat_t exp_q[$];
    logic  err_exp = 1'b0;

    always #5 clk = ~clk;

    encoder_bitscan_iter #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(l_ready), .in_vec(in_vec),
        .out_valid(l_valid), .out_ready(out_ready), .out_idx(l_idx),
        .out_last(l_last), .out_zero(l_zero)
`ifdef ENCODER_ONEHOT_CHK_EN
        , .onehot_err(l_err)
`endif
    );

    encoder_bitscan_iter #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(m_ready), .in_vec(in_vec),
        .out_valid(m_valid), .out_ready(out_ready), .out_idx(m_idx),
        .out_last(m_last), .out_zero(m_zero)
`ifdef ENCODER_ONEHOT_CHK_EN
        , .onehot_err(m_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int idx, input logic last, input logic zero);
        beat_t b;
        b.idx  = 4'(idx);
        b.last = last;
        b.zero = zero;
        return b;
    endfunction

    task automatic e(input int idx, input logic last, input logic zero);
        exp_q.push_back(mk(idx, last, zero));
    endtask

    task automatic check_log(input string name, input beat_t got[$], input beat_t exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    // Per-cycle compare, then advance the model to what the next edge will do.
    always @(negedge clk) begin : monitor
        int cnt;
        int k;
        chk("lsb_valid", l_valid, q_l.size() != 0);
        chk("msb_valid", m_valid, q_m.size() != 0);
        if (q_l.size() != 0) begin
            chk("lsb_beat", {l_idx, l_last, l_zero}, 32'(q_l[0]));
        end
        if (q_m.size() != 0) begin
            chk("msb_beat", {m_idx, m_last, m_zero}, 32'(q_m[0]));
        end
        chk("lsb_in_ready", l_ready, (q_l.size() == 0) && enable && !reset);
        chk("msb_in_ready", m_ready, (q_m.size() == 0) && enable && !reset);
`ifdef ENCODER_ONEHOT_CHK_EN
        chk("lsb_onehot_err", l_err, err_exp);
        chk("msb_onehot_err", m_err, err_exp);
`endif
        if (l_valid && out_ready && !reset) log_l.push_back(mk(int'(l_idx), l_last, l_zero));
        if (m_valid && out_ready && !reset) log_m.push_back(mk(int'(m_idx), m_last, m_zero));

        if (reset) begin
            q_l.delete();
            q_m.delete();
            err_exp = 1'b0;
        end else if (q_l.size() != 0) begin
            if (out_ready) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
        end else if (in_valid && enable) begin
            cnt = $countones(in_vec);
            if (cnt != 1) err_exp = 1'b1;
            if (cnt == 0) begin
                q_l.push_back(mk(0, 1'b1, 1'b1));
                q_m.push_back(mk(0, 1'b1, 1'b1));
            end else begin
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    if (in_vec[i]) begin
                        k++;
                        q_l.push_back(mk(i, k == cnt, 1'b0));
                    end
                end
                k = 0;
                for (int i = 15; i >= 0; i--) begin
                    if (in_vec[i]) begin
                        k++;
                        q_m.push_back(mk(i, k == cnt, 1'b0));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        int n;
        in_valid = 1'b1;
        in_vec   = v;
        n = 0;
        @(negedge clk);
        while (!l_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_l.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic clear_logs();
        log_l.delete();
        log_m.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("reset_valid", l_valid, 1'b0);
        chk("reset_idx", l_idx, 4'd0);
        chk("reset_last", l_last, 1'b0);
        chk("reset_zero", l_zero, 1'b0);
        chk("reset_ready", l_ready, 1'b0);
        step();
        reset = 1'b0;

        // Single one-hot vector
        clear_logs();
        send(16'h0008);
        drain();
        @(negedge clk);
        chk("idle_ready_after", l_ready, 1'b1);
        e(3, 1'b1, 1'b0);
        check_log("onehot_lsb", log_l, exp_q);
        check_log("onehot_msb", log_m, exp_q);
        step();

        // Multi-hot, full throughput
        clear_logs();
        out_ready = 1'b1;
        send(16'h8421);
        drain();
        e(0, 1'b0, 1'b0); e(5, 1'b0, 1'b0); e(10, 1'b0, 1'b0); e(15, 1'b1, 1'b0);
        check_log("8421_lsb", log_l, exp_q);
        exp_q.delete();
        e(15, 1'b0, 1'b0); e(10, 1'b0, 1'b0); e(5, 1'b0, 1'b0); e(0, 1'b1, 1'b0);
        check_log("8421_msb", log_m, exp_q);

        // All-zero vector
        clear_logs();
        send(16'h0000);
        drain();
        e(0, 1'b1, 1'b1);
        check_log("zero_lsb", log_l, exp_q);
        check_log("zero_msb", log_m, exp_q);

        // Stall with out_ready low for three cycles
        clear_logs();
        out_ready = 1'b0;
        send(16'h0006);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", l_valid, 1'b1);
            chk("stall_idx", l_idx, 4'd1);
            chk("stall_last", l_last, 1'b0);
        end
        step();
        out_ready = 1'b1;
        drain();
        e(1, 1'b0, 1'b0); e(2, 1'b1, 1'b0);
        check_log("stall_lsb", log_l, exp_q);
        exp_q.delete();
        e(2, 1'b0, 1'b0); e(1, 1'b1, 1'b0);
        check_log("stall_msb", log_m, exp_q);

        // Reset after the second beat of a full vector
        clear_logs();
        send(16'hFFFF);
        n = 0;
        while (log_l.size() < 2 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("ffff_timeout", 32'd1, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", l_valid, 1'b0);
        chk("midrst_valid_msb", m_valid, 1'b0);
        e(0, 1'b0, 1'b0); e(1, 1'b0, 1'b0);
        check_log("midrst_lsb", log_l, exp_q);
        exp_q.delete();
        e(15, 1'b0, 1'b0); e(14, 1'b0, 1'b0);
        check_log("midrst_msb", log_m, exp_q);
        step();
        clear_logs();
        send(16'h0010);
        drain();
        e(4, 1'b1, 1'b0);
        check_log("after_rst_lsb", log_l, exp_q);
        check_log("after_rst_msb", log_m, exp_q);

        // enable dropped mid-scan: scan finishes, new vectors blocked
        clear_logs();
        send(16'h0005);
        enable = 1'b0;
        drain();
        in_valid = 1'b1;
        in_vec   = 16'h0100;
        repeat (3) begin
            @(negedge clk);
            chk("disabled_ready", l_ready, 1'b0);
            chk("disabled_valid", l_valid, 1'b0);
        end
        step();
        enable = 1'b1;
        send(16'h0100);
        drain();
        e(0, 1'b0, 1'b0); e(2, 1'b1, 1'b0); e(8, 1'b1, 1'b0);
        check_log("enable_lsb", log_l, exp_q);
        exp_q.delete();
        e(2, 1'b0, 1'b0); e(0, 1'b1, 1'b0); e(8, 1'b1, 1'b0);
        check_log("enable_msb", log_m, exp_q);

`ifdef ENCODER_ONEHOT_CHK_EN
        // Sticky one-hot checker
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(16'h0010);
        drain();
        @(negedge clk);
        chk("err_after_onehot", l_err, 1'b0);
        step();
        send(16'h0011);
        drain();
        @(negedge clk);
        chk("err_after_multihot", l_err, 1'b1);
        step();
        send(16'h0020);
        drain();
        @(negedge clk);
        chk("err_sticky", l_err, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared", l_err, 1'b0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/encoder_bitscan_iter.md
Name: encoder_bitscan_iter

Overview:
- Parametrised, sequential successor to the fixed 16:4 one-hot encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake, then emits the binary index of every set bit, one index per output beat.
- Scan order is fixed by parameter; the last beat of each vector is marked.
- Sits between request collectors (interrupt/event lines) and downstream index consumers, so multi-hot inputs are serialised instead of mis-encoded.

Parameters:
- WIDTH, 16, number of input request bits; legal range 2..256.
- IDX_W, $clog2(WIDTH), output index width; derived, do not override.
- MSB_FIRST, 0, 0 = emit indices in ascending order, 1 = descending.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  gates acceptance of new vectors; does not stop a scan in progress.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  request vector.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  downstream accepts the current beat.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  current beat is the final beat of this vector.
- out_zero  output  1  accepted vector was all-zero; valid with out_valid.

Behaviour:
- States: IDLE, SCAN. Internal registers: mask[WIDTH] holds the remaining bits; zero_flag.
- Reset values: state=IDLE, mask=0, out_valid=0, out_idx=0, out_last=0, out_zero=0, in_ready=0 in the reset cycle.
- in_ready = (state==IDLE) && enable && !reset.
- Accept happens when in_valid && in_ready.
  - mask <= in_vec.
  - zero_flag <= (in_vec==0).
  - state <= SCAN.
- Latency: the first out_valid is asserted on the cycle after the accept.
- In SCAN:
  - out_valid=1.
  - out_idx = lowest set bit of mask (highest if MSB_FIRST=1).
  - out_last = mask has at most one bit set.
  - out_zero = zero_flag.
- Beat transfer happens when out_valid && out_ready.
  - The emitted bit is cleared in mask.
  - If out_last, state <= IDLE.
  - Otherwise the next index appears on the following cycle. Throughput is 1 beat/cycle.
- Stall (out_ready=0): out_idx, out_last and out_zero stay stable and out_valid stays high.
- All-zero vector produces exactly one beat: out_idx=0, out_zero=1, out_last=1.
- Full vector (all ones) produces WIDTH beats, indices 0..WIDTH-1 (or reversed for MSB_FIRST=1).
- Vector throughput: no new accept while in SCAN. Minimum gap is one IDLE cycle between the last beat and the next accept.
- enable low during SCAN: the scan completes normally; only new accepts are blocked.
- reset mid-scan: the remaining bits are discarded, out_valid drops on the next edge, and no partial beats follow.
- Outputs are driven from registers (mask/state) through the find-first-set logic. There is no combinational path from in_* to out_*.

Optional Feature:
- Macro: ENCODER_ONEHOT_CHK_EN.
- Defined:
  - Adds output port onehot_err (1 bit).
  - onehot_err is a sticky register, set on any accepted vector whose popcount != 1 (including zero).
  - It is cleared only by reset and is visible from the cycle after the accept.
- Not defined:
  - The port and its logic are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package encoder_pkg:
  - State enum (IDLE, SCAN).
  - Localparam helper for IDX_W.
  - Function for single-bit clear mask generation.
- Sub-module encoder_ffs:
  - Combinational find-first-set, parametrised on WIDTH and MSB_FIRST.
  - Outputs index, any and onehot_or_zero (at most one bit set), and is reused for the out_last computation.

Test Plan:
- Reset, then in_vec=16'h0008 accepted → one beat: out_idx=3, out_last=1, out_zero=0, then return to IDLE with in_ready=1.
- in_vec=16'h8421, out_ready=1 → beats 0,5,10,15 on consecutive cycles, out_last only on 15; with MSB_FIRST=1 → 15,10,5,0.
- in_vec=16'h0000 → single beat: out_idx=0, out_zero=1, out_last=1.
- in_vec=16'h0006 with out_ready held low 3 cycles → out_idx=1 stays stable with out_valid=1; then 1 and 2 are emitted, no loss or duplication.
- reset asserted after the 2nd beat of 16'hFFFF → out_valid=0 after the next edge, and next vector 16'h0010 yields only out_idx=4.
- With ENCODER_ONEHOT_CHK_EN: 16'h0010 → onehot_err=0; then 16'h0011 → onehot_err=1 and stays 1 through later one-hot vectors until reset.
